// File: rtl/fft_pkg.sv
// Shared constants and sample types for the radix-2 FFT datapath stages.
// Every sample vector is ARRAY lanes wide; each lane carries one complex component.
package fft_pkg;

  localparam int ARRAY   = 16;
  localparam int IN_W    = 11;
  localparam int OUT_W   = 12;
  localparam int IDX_W   = 5;
  localparam int BLK_CYC = 4;

  typedef logic signed [IN_W-1:0]  in_smp_t;
  typedef logic signed [OUT_W-1:0] out_smp_t;
  typedef in_smp_t  in_vec_t  [ARRAY];
  typedef out_smp_t out_vec_t [ARRAY];
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {DP_IDLE, DP_D0, DP_D1} diff_ph_e;

endpackage

// File: rtl/fft_bf1_stride32_if.sv
// Sample and index bus of the stride-32 butterfly.
// The source side is the master; the butterfly is the slave.
interface fft_bf1_stride32_if;
  import fft_pkg::*;

  logic     val_in;
  in_vec_t  re_in;
  in_vec_t  im_in;
  idx_t     index_in;

  logic     val_out;
  out_vec_t re_out;
  out_vec_t im_out;
  idx_t     index_out;

  modport master (
    output val_in, re_in, im_in, index_in,
    input  val_out, re_out, im_out, index_out
  );

  modport slave (
    input  val_in, re_in, im_in, index_in,
    output val_out, re_out, im_out, index_out
  );

endinterface

// File: rtl/fft_bf2_lane.sv
// One complex radix-2 butterfly lane: a+b and a-b, sign-extended by one bit.
// Purely combinational; the one extra bit makes overflow impossible.
module fft_bf2_lane
  import fft_pkg::*;
(
  input  in_smp_t  a_re_i,
  input  in_smp_t  a_im_i,
  input  in_smp_t  b_re_i,
  input  in_smp_t  b_im_i,
  output out_smp_t sum_re_o,
  output out_smp_t sum_im_o,
  output out_smp_t dif_re_o,
  output out_smp_t dif_im_o
);

  out_smp_t a_re_x, a_im_x, b_re_x, b_im_x;

  assign a_re_x = {a_re_i[IN_W-1], a_re_i};
  assign a_im_x = {a_im_i[IN_W-1], a_im_i};
  assign b_re_x = {b_re_i[IN_W-1], b_re_i};
  assign b_im_x = {b_im_i[IN_W-1], b_im_i};

  assign sum_re_o = a_re_x + b_re_x;
  assign sum_im_o = a_im_x + b_im_x;
  assign dif_re_o = a_re_x - b_re_x;
  assign dif_im_o = a_im_x - b_im_x;

endmodule

// File: rtl/fft_bf1_stride32.sv
// Stage-1 butterfly: pairs samples 32 apart in each 64-point block (4 cycles x 16 lanes).
// Emits S0,S1 one cycle after c2,c3, then D0,D1 from stored differences.
module fft_bf1_stride32
  import fft_pkg::*;
(
  input logic               clk,
  input logic               rstn,
  fft_bf1_stride32_if.slave bus
);

  localparam int CNT_W = $clog2(BLK_CYC);

  logic [CNT_W-1:0] cnt_q;
  in_vec_t          a0_re_q, a0_im_q, a1_re_q, a1_im_q;
  out_vec_t         d0_re_q, d0_im_q, d1_re_q, d1_im_q;
  idx_t             idx_hold_q, idx_diff_q, idx_q;
  diff_ph_e         dph_q;
  logic             val_q;
  out_vec_t         re_q, im_q;

  in_vec_t          op_re, op_im;
  out_vec_t         sum_re, sum_im, dif_re, dif_im;
  logic             sum_cyc;

  // c2 pairs with A0, c3 with A1; only those two cycles use the lanes.
  assign sum_cyc = bus.val_in && cnt_q[1];

  always_comb begin
    for (int k = 0; k < ARRAY; k++) begin
      op_re[k] = cnt_q[0] ? a1_re_q[k] : a0_re_q[k];
      op_im[k] = cnt_q[0] ? a1_im_q[k] : a0_im_q[k];
    end
  end

  for (genvar k = 0; k < ARRAY; k++) begin : g_lane
    fft_bf2_lane u_lane (
      .a_re_i   (op_re[k]),
      .a_im_i   (op_im[k]),
      .b_re_i   (bus.re_in[k]),
      .b_im_i   (bus.im_in[k]),
      .sum_re_o (sum_re[k]),
      .sum_im_o (sum_im[k]),
      .dif_re_o (dif_re[k]),
      .dif_im_o (dif_im[k])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      a0_re_q    <= '{default: '0};
      a0_im_q    <= '{default: '0};
      a1_re_q    <= '{default: '0};
      a1_im_q    <= '{default: '0};
      d0_re_q    <= '{default: '0};
      d0_im_q    <= '{default: '0};
      d1_re_q    <= '{default: '0};
      d1_im_q    <= '{default: '0};
      idx_hold_q <= '0;
      idx_diff_q <= '0;
      idx_q      <= '0;
      dph_q      <= DP_IDLE;
      val_q      <= 1'b0;
      re_q       <= '{default: '0};
      im_q       <= '{default: '0};
    end else begin
      cnt_q <= bus.val_in ? cnt_q + 1'b1 : '0;

      if (bus.val_in) begin
        case (cnt_q)
          2'd0: begin
            a0_re_q    <= bus.re_in;
            a0_im_q    <= bus.im_in;
            idx_hold_q <= bus.index_in;
          end
          2'd1: begin
            a1_re_q <= bus.re_in;
            a1_im_q <= bus.im_in;
          end
          2'd2: begin
            d0_re_q <= dif_re;
            d0_im_q <= dif_im;
          end
          default: begin
            d1_re_q    <= dif_re;
            d1_im_q    <= dif_im;
            idx_diff_q <= idx_hold_q;
          end
        endcase
      end

      // Diff phase never collides with a sum cycle: the next c2 is at least 3 cycles after c3.
      if (sum_cyc) begin
        val_q <= 1'b1;
        re_q  <= sum_re;
        im_q  <= sum_im;
        idx_q <= idx_hold_q;
      end else if (dph_q == DP_D0) begin
        val_q <= 1'b1;
        re_q  <= d0_re_q;
        im_q  <= d0_im_q;
        idx_q <= idx_diff_q;
      end else if (dph_q == DP_D1) begin
        val_q <= 1'b1;
        re_q  <= d1_re_q;
        im_q  <= d1_im_q;
        idx_q <= idx_diff_q;
      end else begin
        val_q <= 1'b0;
        re_q  <= '{default: '0};
        im_q  <= '{default: '0};
      end

      if (bus.val_in && cnt_q == 2'd3) begin
        dph_q <= DP_D0;
      end else if (dph_q == DP_D0) begin
        dph_q <= DP_D1;
      end else begin
        dph_q <= DP_IDLE;
      end
    end
  end

  assign bus.val_out   = val_q;
  assign bus.re_out    = re_q;
  assign bus.im_out    = im_q;
  assign bus.index_out = idx_q;

endmodule

// File: tb/tb_fft_bf1_stride32.sv
// Bench for fft_bf1_stride32: drives whole, aborted and back-to-back blocks,
// predicts every output cycle into a scoreboard and checks it at the falling edge.
module tb_fft_bf1_stride32;
  import fft_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  fft_bf1_stride32_if bus ();

  fft_bf1_stride32 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int cyc;
    int re [ARRAY];
    int im [ARRAY];
    int idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   last_idx = 0;
  int   blk_re [4][ARRAY];
  int   blk_im [4][ARRAY];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int count_nz();
    int nz = 0;
    for (int k = 0; k < ARRAY; k++)
      if (bus.re_out[k] != 0 || bus.im_out[k] != 0) nz++;
    return nz;
  endfunction

  task automatic drive(input logic v, input int c, input int idx);
    @(posedge clk);
    #1;
    bus.val_in   = v;
    bus.index_in = idx_t'(idx);
    for (int k = 0; k < ARRAY; k++) begin
      bus.re_in[k] = v ? in_smp_t'(blk_re[c][k]) : '0;
      bus.im_in[k] = v ? in_smp_t'(blk_im[c][k]) : '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
  endtask

  // Predicts outputs from the bench's own copy of the block; diffs only once c3 is sent.
  task automatic send_block(input int ncyc, input int idx);
    exp_t e;
    for (int c = 0; c < ncyc; c++) begin
      drive(1'b1, c, idx);
      e.idx = idx;
      if (c == 2) begin
        e.cyc = cyc + 1;
        for (int k = 0; k < ARRAY; k++) begin
          e.re[k] = blk_re[0][k] + blk_re[2][k];
          e.im[k] = blk_im[0][k] + blk_im[2][k];
        end
        sb.push_back(e);
      end
      if (c == 3) begin
        e.cyc = cyc + 1;
        for (int k = 0; k < ARRAY; k++) begin
          e.re[k] = blk_re[1][k] + blk_re[3][k];
          e.im[k] = blk_im[1][k] + blk_im[3][k];
        end
        sb.push_back(e);
        e.cyc = cyc + 2;
        for (int k = 0; k < ARRAY; k++) begin
          e.re[k] = blk_re[0][k] - blk_re[2][k];
          e.im[k] = blk_im[0][k] - blk_im[2][k];
        end
        sb.push_back(e);
        e.cyc = cyc + 3;
        for (int k = 0; k < ARRAY; k++) begin
          e.re[k] = blk_re[1][k] - blk_re[3][k];
          e.im[k] = blk_im[1][k] - blk_im[3][k];
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic set_cyc(input int c, input int re, input int im);
    for (int k = 0; k < ARRAY; k++) begin
      blk_re[c][k] = re;
      blk_im[c][k] = im;
    end
  endtask

  task automatic set_ramp();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < ARRAY; k++) begin
        blk_re[c][k] = 16 * c + k;
        blk_im[c][k] = -(16 * c + k);
      end
  endtask

  task automatic set_random();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < ARRAY; k++) begin
        blk_re[c][k] = int'($urandom_range(2047)) - 1024;
        blk_im[c][k] = int'($urandom_range(2047)) - 1024;
      end
  endtask

  always @(negedge clk) begin
    if (bus.val_out) begin
      if (sb.size() == 0) begin
        check_val("unexpected_val_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("out_cycle", cyc, mon_e.cyc);
        for (int k = 0; k < ARRAY; k++) begin
          check_val("re_out", int'(bus.re_out[k]), mon_e.re[k]);
          check_val("im_out", int'(bus.im_out[k]), mon_e.im[k]);
        end
        check_val("index_out", int'(bus.index_out), mon_e.idx);
        last_idx = mon_e.idx;
      end
    end else begin
      check_val("idle_data_nonzero_lanes", count_nz(), 0);
      check_val("idle_index_hold", int'(bus.index_out), last_idx);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check_val("missing_output_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.val_in   = 1'b0;
    bus.index_in = '0;
    for (int k = 0; k < ARRAY; k++) begin
      bus.re_in[k] = '0;
      bus.im_in[k] = '0;
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_val_out", int'(bus.val_out), 0);
    check_val("rst_data", count_nz(), 0);
    check_val("rst_index", int'(bus.index_out), 0);
    rstn = 1'b1;
    idle(2);

    // Constant block.
    for (int c = 0; c < 4; c++) set_cyc(c, 100, -50);
    send_block(4, 7);
    idle(4);

    // Extremes in both directions.
    set_cyc(0, 1023, -1024); set_cyc(1, 1023, -1024);
    set_cyc(2, -1024, 1023); set_cyc(3, -1024, 1023);
    send_block(4, 31);
    idle(3);
    set_cyc(0, -1024, 1023); set_cyc(1, -1024, 1023);
    set_cyc(2, 1023, -1024); set_cyc(3, 1023, -1024);
    send_block(4, 1);
    idle(3);

    // Back-to-back ramp blocks.
    set_ramp();
    send_block(4, 3);
    send_block(4, 9);
    idle(4);

    // Abort after c2, then a full block.
    set_random();
    send_block(3, 5);
    idle(3);
    set_random();
    send_block(4, 14);
    idle(4);

    // Gap of 5 idle cycles between blocks.
    set_random();
    send_block(4, 20);
    idle(5);
    set_random();
    send_block(4, 21);

    // Random back-to-back run.
    for (int b = 0; b < 4; b++) begin
      set_random();
      send_block(4, int'($urandom_range(31)));
    end
    idle(6);

    // Asynchronous reset while D0 is on the outputs.
    set_random();
    send_block(4, 12);
    idle(1);
    @(posedge clk);
    #1;
    check_val("pre_rst_diff_val", int'(bus.val_out), 1);
    rstn = 1'b0;
    #1;
    check_val("async_rst_val_out", int'(bus.val_out), 0);
    check_val("async_rst_data", count_nz(), 0);
    check_val("async_rst_index", int'(bus.index_out), 0);
    sb.delete();
    last_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(6);
    set_random();
    send_block(4, 27);

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    idle(2);
    check_val("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_bf1_stride32.md
Name: fft_bf1_stride32

Overview:
- Stage-1 radix-2 butterfly that directly consumes the CBFP stage-0 output.
- Input is 16 parallel complex 11-bit samples per cycle, in 64-point blocks of 4 consecutive valid cycles.
- Pairs samples 32 apart within each block and emits sums then differences at 12-bit width.
- Carries the block's CBFP shift index alongside the data for the downstream twiddle/CBFP stages.

Parameters:
- IN_W, 11, input sample width (signed)
- OUT_W, 12, output sample width; must equal IN_W+1
- ARRAY, 16, parallel lanes per cycle
- IDX_W, 5, CBFP index width

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- val_in  in  1  input valid; high for whole 4-cycle blocks
- re_in  in  [IN_W-1:0] x ARRAY, unpacked [0:ARRAY-1]  signed real lanes
- im_in  in  [IN_W-1:0] x ARRAY  signed imaginary lanes
- index_in  in  IDX_W  CBFP shift index of current block; valid while val_in
- re_out  out  [OUT_W-1:0] x ARRAY  signed real result
- im_out  out  [OUT_W-1:0] x ARRAY  signed imaginary result
- val_out  out  1  output valid
- index_out  out  IDX_W  index of block currently output

Behaviour:
- Reset: all outputs and all internal state go to 0 asynchronously: val_out=0, re_out/im_out=0, index_out=0, counter=0, buffers=0, diff-pending=0.
- Block counter cnt (2-bit):
  - Increments on every val_in=1 cycle and wraps 3->0.
  - Forced to 0 on any val_in=0 cycle.
  - Input cycles c0..c3 correspond to cnt=0..3.
- c0, c1: store the inputs in hold buffers A0/A1 (ARRAY complex each). On c0, also latch index_in into idx_hold.
- c2: registered output sum(A0+c2), lane-wise; compute diff(A0-c2) and store it in D0.
- c3: registered output sum(A1+c3); store diff(A1-c3) in D1; set diff-pending. Copy idx_hold into idx_diff.
- Diff phase: on the two cycles after c3 is registered, output D0, then D1, both with index idx_diff. This is independent of val_in; new block c0/c1 may arrive concurrently and write only A0/A1.
- Output timing: registered, 1-cycle latency from c2. With c0 at cycle t, val_out is high for t+3..t+6 in the order S0, S1, D0, D1. Back-to-back blocks give continuous val_out with no gaps or overlap.
- index_out: equals idx_hold during sum cycles and idx_diff during diff cycles. It holds its last value when val_out=0.
- Arithmetic:
  - Operands are sign-extended to OUT_W before add/sub.
  - No saturation; the full result fits in OUT_W.
  - re and im are handled identically and independently.
- Outputs while val_out=0: re_out/im_out are driven to 0.
- Abort (val_in drops mid-block, protocol violation):
  - cnt returns to 0.
  - Sums already emitted stand.
  - If c3 was not accepted, no diffs are emitted for that block.
  - The next val_in cycle is treated as c0.
- val_in gap between complete blocks: pending diffs still drain; no effect on correctness.
- Reset mid-operation: pending diffs are discarded; the first post-reset valid cycle is c0.

Decomposition:
- Shared package fft_pkg holds:
  - constants ARRAY=16, IN_W=11, OUT_W=12, IDX_W=5, BLK_CYC=4
  - typedef for a signed OUT_W sample
  - typedef for an ARRAY-lane vector of it
- One natural sub-module, fft_bf2_lane: combinational sign-extend plus add/sub for one complex pair. Instantiate it ARRAY times via generate.

Test Plan:
- Single block: all lanes re=100, im=-50 on c0..c3, index_in=7 -> val_out high 4 cycles starting 3 cycles after c0. Expected re_out=200,200,0,0 and im_out=-100,-100,0,0; index_out=7 throughout.
- Extremes: c0/c1 lanes re=1023, c2/c3 lanes re=-1024 -> sums=-1, diffs=2047, with no overflow or wrap. Repeat with c0=-1024, c2=1023 -> diff=-2047.
- Back-to-back blocks, index 3 then 9, lane k of cycle c = 16*c+k -> 8 contiguous val_out cycles. Block 1 diff cycles show index 3 and the next sum cycles show 9. Each lane's diff equals -32.
- Abort: val_in high for 3 cycles then low -> exactly 1 val_out cycle (S0) and no diffs. A following full block is output correctly.
- Async reset asserted during a diff-phase cycle -> val_out, re_out/im_out and index_out are 0 immediately. After release, no stale diff is output.
- Gap: two blocks separated by 5 idle cycles -> two 4-cycle val_out bursts with correct per-block index, and zeros on the data outputs in between.
